// File: rtl/sram_wr_arbiter.sv
// sram_wr_arbiter: round-robin arbiter sharing one SRAM write port among
// N_PORTS SGDMA writers, with bounded bursts and SRAM-busy back-off.
// Ports: i_clk, i_rst_n (async, active-low)
//        i_wr_req/i_wr_addr/i_wr_dat : per-port request and flattened beat
//        o_wr_ready                  : registered one-hot acceptance
//        i_sram_busy                 : SRAM write port unavailable
//        o_sram_wr_en/addr/dat       : registered SRAM write
//        o_grant_id                  : port written this cycle
module sram_wr_arbiter #(
   parameter int N_PORTS   = 4,
   parameter int ADDR_W    = 12,
   parameter int DATA_W    = 128,
   parameter int MAX_BURST = 8
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic [N_PORTS-1:0]          i_wr_req,
   input  logic [N_PORTS*ADDR_W-1:0]   i_wr_addr,
   input  logic [N_PORTS*DATA_W-1:0]   i_wr_dat,
   output logic [N_PORTS-1:0]          o_wr_ready,
   input  logic                        i_sram_busy,
   output logic                        o_sram_wr_en,
   output logic [ADDR_W-1:0]           o_sram_wr_addr,
   output logic [DATA_W-1:0]           o_sram_wr_dat,
   output logic [2:0]                  o_grant_id
);

   logic [2:0]         owner;
   logic [2:0]         owner_nxt;
   logic [7:0]         burst;
   logic [7:0]         burst_nxt;
   logic [7:0]         req_ext;
   logic [7:0]         others;
   logic               grant;
   logic               found;
   logic [2:0]         winner;
   logic [2:0]         idx;
   logic [N_PORTS-1:0] ready_nxt;
   logic [ADDR_W-1:0]  sel_addr;
   logic [DATA_W-1:0]  sel_dat;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         owner <= 3'(N_PORTS - 1);
         burst <= 8'd0;
      end else begin
         owner <= owner_nxt;
         burst <= burst_nxt;
      end
   end

   // burst == 0 only right after reset: the reset owner holds no real
   // grant, so the first arbitration scans from port 0.
   always_comb begin
      req_ext   = 8'(i_wr_req);
      others    = req_ext & ~(8'd1 << owner);
      owner_nxt = owner;
      burst_nxt = burst;
      grant     = 1'b0;
      found     = 1'b0;
      winner    = owner;
      idx       = 3'd0;
      if (!i_sram_busy && (req_ext != 8'd0)) begin
         grant = 1'b1;
         if (req_ext[owner] && (burst != 8'd0) &&
             ((burst < 8'(MAX_BURST)) || (others == 8'd0))) begin
            if (burst < 8'(MAX_BURST)) begin
               burst_nxt = burst + 8'd1;
            end
         end else begin
            for (int k = 1; k <= N_PORTS; k++) begin
               idx = 3'((int'(owner) + k) % N_PORTS);
               if (!found && req_ext[idx]) begin
                  found  = 1'b1;
                  winner = idx;
               end
            end
            owner_nxt = winner;
            burst_nxt = 8'd1;
         end
      end
   end

   always_comb begin
      ready_nxt = '0;
      sel_addr  = '0;
      sel_dat   = '0;
      for (int n = 0; n < N_PORTS; n++) begin
         if (winner == 3'(n)) begin
            ready_nxt[n] = grant;
            sel_addr     = i_wr_addr[n*ADDR_W +: ADDR_W];
            sel_dat      = i_wr_dat[n*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_wr_ready     <= '0;
         o_sram_wr_en   <= 1'b0;
         o_sram_wr_addr <= '0;
         o_sram_wr_dat  <= '0;
         o_grant_id     <= 3'd0;
      end else begin
         o_wr_ready   <= ready_nxt;
         o_sram_wr_en <= grant;
         if (grant) begin
            o_sram_wr_addr <= sel_addr;
            o_sram_wr_dat  <= sel_dat;
            o_grant_id     <= winner;
         end
      end
   end

endmodule

// File: tb/tb_sram_wr_arbiter.sv
// tb_sram_wr_arbiter: directed and randomized bench for sram_wr_arbiter
// with a behavioural round-robin model and requester beat tracking.
module tb_sram_wr_arbiter;

   localparam int N  = 4;
   localparam int AW = 12;
   localparam int DW = 128;
   localparam int MB = 8;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    req = '0;
   logic [N*AW-1:0] addr_bus = '0;
   logic [N*DW-1:0] dat_bus = '0;
   logic            busy = 1'b0;
   logic [N-1:0]    o_wr_ready;
   logic            o_sram_wr_en;
   logic [AW-1:0]   o_sram_wr_addr;
   logic [DW-1:0]   o_sram_wr_dat;
   logic [2:0]      o_grant_id;

   sram_wr_arbiter #(
      .N_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)
   ) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_wr_req       (req),
      .i_wr_addr      (addr_bus),
      .i_wr_dat       (dat_bus),
      .o_wr_ready     (o_wr_ready),
      .i_sram_busy    (busy),
      .o_sram_wr_en   (o_sram_wr_en),
      .o_sram_wr_addr (o_sram_wr_addr),
      .o_sram_wr_dat  (o_sram_wr_dat),
      .o_grant_id     (o_grant_id)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int n2a0   = 0;

   logic [AW-1:0] pa [N];
   logic [DW-1:0] pd [N];
   bit            has [N];

   int            m_owner;
   int            m_burst;
   logic          exp_en;
   logic [AW-1:0] exp_addr;
   logic [DW-1:0] exp_dat;
   logic [2:0]    exp_gid;
   logic [N-1:0]  exp_ready;

   task automatic check(input string tag, input logic [127:0] got,
                        input logic [127:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      req   = '0;
      busy  = 1'b0;
      #1;
      check("rst_en_now", o_sram_wr_en, 0);
      check("rst_ready_now", o_wr_ready, 0);
      @(posedge clk);
      #1;
      check("rst_addr", o_sram_wr_addr, 0);
      check("rst_dat", o_sram_wr_dat, 0);
      check("rst_gid", o_grant_id, 0);
      rst_n     = 1'b1;
      m_owner   = N - 1;
      m_burst   = 0;
      exp_en    = 1'b0;
      exp_addr  = '0;
      exp_dat   = '0;
      exp_gid   = 3'd0;
      exp_ready = '0;
      for (int p = 0; p < N; p++) has[p] = 1'b0;
   endtask

   // Drive one cycle of requests, predict the registered result, check it.
   task automatic cyc(input logic [N-1:0] act, input bit b);
      int  win;
      bit  others;
      int  p2;
      for (int p = 0; p < N; p++) begin
         if (act[p] && !has[p]) begin
            pa[p]  = AW'($urandom_range(0, 12'h29F));
            pd[p]  = {$urandom, $urandom, $urandom, $urandom};
            has[p] = 1'b1;
         end
         req[p] = act[p] && has[p];
         addr_bus[p*AW +: AW] = pa[p];
         dat_bus[p*DW +: DW]  = pd[p];
      end
      busy = b;
      win = -1;
      if (!b && req != '0) begin
         others = 1'b0;
         for (int p = 0; p < N; p++)
            if (p != m_owner && req[p]) others = 1'b1;
         if (req[m_owner] && m_burst > 0 && (m_burst < MB || !others)) begin
            win = m_owner;
            if (m_burst < MB) m_burst = m_burst + 1;
         end else begin
            for (int k = 1; k <= N; k++) begin
               p2 = (m_owner + k) % N;
               if (win < 0 && req[p2]) win = p2;
            end
            m_owner = win;
            m_burst = 1;
         end
      end
      if (win >= 0) begin
         exp_en    = 1'b1;
         exp_addr  = pa[win];
         exp_dat   = pd[win];
         exp_gid   = 3'(win);
         exp_ready = N'(1) << win;
      end else begin
         exp_en    = 1'b0;
         exp_ready = '0;
      end
      @(posedge clk);
      #1;
      check("wr_en", o_sram_wr_en, exp_en);
      check("wr_addr", o_sram_wr_addr, exp_addr);
      check("wr_dat", o_sram_wr_dat, exp_dat);
      check("grant_id", o_grant_id, exp_gid);
      check("ready", o_wr_ready, exp_ready);
      if (o_sram_wr_en && o_sram_wr_addr == 12'h2A0) n2a0++;
      for (int p = 0; p < N; p++)
         if (exp_ready[p]) has[p] = 1'b0;
   endtask

   initial begin
      logic [N-1:0] act;
      bit           b;
      for (int p = 0; p < N; p++) begin
         pa[p]  = '0;
         pd[p]  = '0;
         has[p] = 1'b0;
      end
      do_reset();

      // lone port 0, addresses 0x010..0x014, one beat per clock
      for (int i = 0; i < 5; i++) begin
         pa[0]  = AW'(12'h010 + i);
         has[0] = 1'b1;
         cyc(4'b0001, 1'b0);
         check("p0_addr", o_sram_wr_addr, 12'h010 + i);
         check("p0_gid", o_grant_id, 0);
         check("p0_en", o_sram_wr_en, 1);
      end
      cyc(4'b0000, 1'b0);
      check("idle_en", o_sram_wr_en, 0);

      // all ports requesting: 8 grants each in order 0,1,2,3,0
      do_reset();
      for (int i = 0; i < 40; i++) begin
         cyc(4'b1111, 1'b0);
         check("fair_gid", o_grant_id, (i / MB) % N);
         check("fair_en", o_sram_wr_en, 1);
      end

      // ports 1 and 3 with busy on cycles 4..6
      for (int i = 1; i <= 10; i++) begin
         b = (i >= 4 && i <= 6);
         cyc(4'b1010, b);
         if (b) check("busy_en", o_sram_wr_en, 0);
      end

      // owner 2 with burst 3 drops, port 0 wins via wrap
      do_reset();
      for (int i = 0; i < 3; i++) cyc(4'b0100, 1'b0);
      cyc(4'b0001, 1'b0);
      check("drop_gid", o_grant_id, 0);

      // loser retry: port 1 holds 0x2A0 until granted, written once
      n2a0   = 0;
      pa[1]  = 12'h2A0;
      pd[1]  = {$urandom, $urandom, $urandom, $urandom};
      has[1] = 1'b1;
      for (int i = 0; i < 14; i++) begin
         act = {2'b00, has[1], 1'b1};
         cyc(act, 1'b0);
      end
      check("retry_once", n2a0, 1);

      // randomized traffic with busy and pauses
      for (int i = 0; i < 1500; i++) begin
         for (int p = 0; p < N; p++) act[p] = ($urandom_range(0, 3) != 0);
         b = ($urandom_range(0, 5) == 0);
         cyc(act, b);
      end

      // async reset mid-burst, then port 0 has first priority
      for (int i = 0; i < 3; i++) cyc(4'b1111, 1'b0);
      do_reset();
      cyc(4'b1111, 1'b0);
      check("post_rst_gid", o_grant_id, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
